alu_exec_unit: RTL and testbench

Parametrised execute stage of the RISC datapath: operand select, variable-amount barrel shifter, ALU, and registered result/status. It extends the single-cycle compute stage with a configurable datapath width, shift amounts, N/V flags, a valid/ready command handshake, and an optional iterative multiplier. It sits between the register-file read ports (A, B) and the writeback mux (C), with status feeding the branch/controller FSM.

---
 rtl/alu_exec_pkg.sv | 38 +++
 rtl/alu_exec_shifter.sv | 27 ++
 rtl/alu_exec_unit.sv | 166 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, shift modes, status bit layout.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package alu_exec_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_IMM_W = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_MVN = 3'b011,
        OP_MUL = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;

    // Assemble the status vector from individual flags.
    function automatic logic [2:0] pack_status(input logic v, input logic n, input logic z);
        logic [2:0] s;
        s       = '0;
        s[ST_V] = v;
        s[ST_N] = n;
        s[ST_Z] = z;
        return s;
    endfunction

endpackage

// File: rtl/alu_exec_shifter.sv
// Combinational barrel shifter for the B operand: none / LSL / LSR / ASR by shamt.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
module alu_exec_shifter
    import alu_exec_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   din,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   dout
);

    // Select shift flavour; logical shifts fill 0, ASR replicates the sign bit.
    always_comb begin
        dout = din;
        case (mode)
            SH_LSL:  dout = din << shamt;
            SH_LSR:  dout = din >> shamt;
            SH_ASR:  dout = WIDTH'($signed(din) >>> shamt);
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: operand select, shifter, ALU, registered C/status; optional shift-add MUL (ALU_EXEC_MUL_EN).
// Latency: single-cycle ops registered on the accepting edge; MUL completes WIDTH edges after accept.
// Backpressure: in_ready drops while a MUL iterates; input ignored then; output has no backpressure.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int IMM_W   = DEF_IMM_W,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               asel,
    input  logic               bsel,
    input  logic               loadc,
    input  logic               loads,
    input  logic [1:0]         shift,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   datapath_in,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    output logic               err,
    output logic [WIDTH-1:0]   C,
    output logic [2:0]         status
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] ain, bin, b_sh, imm, alu_res;
    logic             alu_v, alu_legal, accept, is_mul;
    logic             done_single, done_mul, ld_c, ld_s;
    logic [WIDTH-1:0] mul_lo, mul_hi;
    logic             wb_fire, wb_err, wb_c_en, wb_s_en;
    logic [WIDTH-1:0] wb_res;
    logic [2:0]       wb_stat;

    // Upper immediate bits are architecturally unused.
    logic unused_imm_hi;
    assign unused_imm_hi = ^datapath_in[WIDTH-1:IMM_W];

    assign ain    = asel ? A : '0;
    assign imm    = {{(WIDTH-IMM_W){1'b0}}, datapath_in[IMM_W-1:0]};
    assign bin    = bsel ? imm : b_sh;
    assign accept = in_valid && in_ready;

    alu_exec_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
        .din   (B),
        .mode  (shift),
        .shamt (shamt),
        .dout  (b_sh)
    );

    // Single-cycle ALU; MUL is decoded separately and is illegal here.
    always_comb begin
        alu_res   = '0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        case (alu_op)
            OP_ADD: begin
                alu_res = ain + bin;
                alu_v   = (ain[MSB] == bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            end
            OP_SUB: begin
                alu_res = ain - bin;
                alu_v   = (ain[MSB] != bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            end
            OP_AND:  alu_res = ain & bin;
            OP_MVN:  alu_res = ~bin;
            default: alu_legal = 1'b0;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, MUL_RUN} state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] mcand, acc, acc_next;
    logic [WIDTH-1:0]   mplier;

    assign is_mul   = (alu_op == OP_MUL);
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign mul_lo   = acc_next[WIDTH-1:0];
    assign mul_hi   = acc_next[2*WIDTH-1:WIDTH];
    assign done_mul = (state == MUL_RUN) && (cnt == CNT_W'(WIDTH - 1));

    // Control FSM: accepts in IDLE, runs one shift-add step per cycle in MUL_RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            ld_c     <= 1'b0;
            ld_s     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        state    <= MUL_RUN;
                        in_ready <= 1'b0;
                        cnt      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, ain};
                        mplier   <= bin;
                        acc      <= '0;
                        ld_c     <= loadc;
                        ld_s     <= loads;
                    end
                end
                MUL_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (done_mul) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign in_ready = 1'b1;
    assign is_mul   = 1'b0;
    assign done_mul = 1'b0;
    assign ld_c     = 1'b0;
    assign ld_s     = 1'b0;
    assign mul_lo   = '0;
    assign mul_hi   = '0;
`endif

    assign done_single = accept && !is_mul;
    assign wb_fire     = done_single || done_mul;
    assign wb_err      = done_single && !alu_legal;
    assign wb_c_en     = done_single ? (alu_legal && loadc) : (done_mul && ld_c);
    assign wb_s_en     = done_single ? (alu_legal && loads) : (done_mul && ld_s);
    assign wb_res      = done_mul ? mul_lo : alu_res;
    assign wb_stat     = done_mul ? pack_status(|mul_hi, mul_lo[MSB], mul_lo == '0)
                                  : pack_status(alu_v, alu_res[MSB], alu_res == '0);

    // Result/status registers and the one-cycle completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C         <= '0;
            status    <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= wb_fire;
            err       <= wb_err;
            if (wb_c_en) C      <= wb_res;
            if (wb_s_en) status <= wb_stat;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized commands vs a reference model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: drives junk while in_ready is low and expects it to be ignored.
module tb_alu_exec_unit;

    localparam int W  = 16;
    localparam int IW = 5;
    localparam int SW = 4;

`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, asel, bsel, loadc, loads;
    logic [1:0]    shift;
    logic [SW-1:0] shamt;
    logic [2:0]    alu_op;
    logic [W-1:0]  datapath_in, A, B, C;
    logic          out_valid, err;
    logic [2:0]    status;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_c;
    logic [2:0]   m_st;

    localparam longint MASK = (longint'(1) << W) - 1;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));

    alu_exec_unit #(.WIDTH(W), .IMM_W(IW), .SHAMT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
        .shift(shift), .shamt(shamt), .alu_op(alu_op), .datapath_in(datapath_in),
        .A(A), .B(B), .out_valid(out_valid), .err(err), .C(C), .status(status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input longint x);
        return (x > SMAX) ? x - (longint'(1) << W) : x;
    endfunction

    // Reference: plain integer arithmetic straight from the operation rules.
    task automatic model(input bit as, input bit bs, input logic [1:0] sh, input logic [SW-1:0] sa,
                         input logic [2:0] op, input logic [W-1:0] dp, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] r, output logic [2:0] st,
                         output bit legal, output bit mul);
        longint ain, bv, bsh, bin, full, sv;
        bit v;
        ain   = as ? longint'(a) : 0;
        bv    = longint'(b);
        case (sh)
            2'd1:    bsh = (bv << sa) & MASK;
            2'd2:    bsh = bv >> sa;
            2'd3:    bsh = (sx(bv) >>> sa) & MASK;
            default: bsh = bv;
        endcase
        bin   = bs ? (longint'(dp) % (longint'(1) << IW)) : bsh;
        full  = 0;
        v     = 1'b0;
        legal = 1'b1;
        mul   = (op == 3'd4);
        case (op)
            3'd0: begin full = ain + bin; sv = sx(ain) + sx(bin); v = (sv > SMAX) || (sv < SMIN); end
            3'd1: begin full = ain - bin; sv = sx(ain) - sx(bin); v = (sv > SMAX) || (sv < SMIN); end
            3'd2: full = ain & bin;
            3'd3: full = ~bin;
            3'd4: begin
                if (MUL_EN) begin full = ain * bin; v = (full >> W) != 0; end
                else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        r  = W'(full & MASK);
        st = {v, r[W-1], (r == '0)};
    endtask

    // Issue one command, follow it to completion and check the result registers.
    task automatic run_cmd(input bit as, input bit bs, input bit lc, input bit ls,
                           input logic [1:0] sh, input logic [SW-1:0] sa, input logic [2:0] op,
                           input logic [W-1:0] dp, input logic [W-1:0] a, input logic [W-1:0] b,
                           input string tag);
        logic [W-1:0] r;
        logic [2:0]   st;
        bit           legal, mul;
        model(as, bs, sh, sa, op, dp, a, b, r, st, legal, mul);
        asel = as; bsel = bs; loadc = lc; loads = ls; shift = sh; shamt = sa;
        alu_op = op; datapath_in = dp; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (mul && legal) begin
            for (int k = 0; k < W; k++) begin
                check({tag, ":busy_ready"}, 64'(in_ready), 64'(0));
                check({tag, ":busy_ovalid"}, 64'(out_valid), 64'(0));
                in_valid = 1'($urandom_range(0, 1));
                A = W'($urandom); B = W'($urandom); alu_op = 3'($urandom_range(0, 3));
                loadc = 1'b1; loads = 1'b1; asel = 1'b1;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
        end
        check({tag, ":out_valid"}, 64'(out_valid), 64'(1));
        check({tag, ":err"}, 64'(err), 64'(!legal));
        if (legal && lc) m_c = r;
        if (legal && ls) m_st = st;
        check({tag, ":C"}, 64'(C), 64'(m_c));
        check({tag, ":status"}, 64'(status), 64'(m_st));
        check({tag, ":in_ready"}, 64'(in_ready), 64'(1));
    endtask

    task automatic idle_cycle(input string tag);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, ":idle_ovalid"}, 64'(out_valid), 64'(0));
        check({tag, ":idle_C"}, 64'(C), 64'(m_c));
    endtask

    initial begin
        int pulses;
        in_valid = 0; asel = 0; bsel = 0; loadc = 0; loads = 0; shift = 0; shamt = 0;
        alu_op = 0; datapath_in = 0; A = 0; B = 0;
        m_c = '0; m_st = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_C", 64'(C), 64'(0));
        check("reset_status", 64'(status), 64'(0));
        check("reset_ovalid", 64'(out_valid), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        check("reset_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(1, 0, 1, 1, 2'd0, 4'd0, 3'd0, 16'h0000, 16'h7FFF, 16'h0001, "add_ovf");
        check("add_ovf_C_const", 64'(C), 64'h8000);
        check("add_ovf_st_const", 64'(status), 64'b110);
        run_cmd(1, 0, 1, 1, 2'd0, 4'd0, 3'd1, 16'h0000, 16'h0005, 16'h0005, "sub_zero");
        check("sub_zero_Z", 64'(status[0]), 64'(1));
        run_cmd(1, 0, 1, 1, 2'd0, 4'd0, 3'd0, 16'h0000, 16'h0001, 16'h0002, "b2b_add");
        run_cmd(1, 1, 1, 1, 2'd0, 4'd0, 3'd0, 16'hFFF3, 16'h0001, 16'h0000, "imm_add");
        check("imm_add_C_const", 64'(C), 64'h0014);
        run_cmd(0, 0, 1, 1, 2'd3, 4'd4, 3'd3, 16'h0000, 16'h0000, 16'h8000, "mvn_asr");
        check("mvn_asr_C_const", 64'(C), 64'h07FF);
        check("mvn_asr_N", 64'(status[1]), 64'(0));
        run_cmd(1, 0, 1, 1, 2'd0, 4'd0, 3'd4, 16'h0000, 16'h0100, 16'h0300, "mul");
        if (MUL_EN) begin
            check("mul_C_const", 64'(C), 64'h0000);
            check("mul_st_const", 64'(status), 64'b101);
        end else begin
            check("mul_illegal_C_const", 64'(C), 64'h07FF);
        end
        run_cmd(1, 0, 1, 1, 2'd0, 4'd0, 3'd0, 16'h0000, 16'h1234, 16'h0000, "set_1234");
        run_cmd(1, 0, 0, 1, 2'd0, 4'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, "noloadc");
        check("noloadc_C_const", 64'(C), 64'h1234);
        check("noloadc_Z", 64'(status[0]), 64'(1));
        run_cmd(1, 0, 1, 1, 2'd0, 4'd0, 3'd5, 16'h0000, 16'h1111, 16'h2222, "illegal5");
        run_cmd(1, 0, 1, 1, 2'd0, 4'd0, 3'd7, 16'h0000, 16'h1111, 16'h2222, "illegal7");
        idle_cycle("idle0");
        run_cmd(1, 0, 1, 1, 2'd1, 4'd15, 3'd0, 16'h0000, 16'h0000, 16'h0001, "lsl15");
        run_cmd(1, 0, 1, 1, 2'd2, 4'd15, 3'd0, 16'h0000, 16'h0000, 16'h8000, "lsr15");
        run_cmd(1, 0, 1, 1, 2'd3, 4'd0, 3'd0, 16'h0000, 16'h0000, 16'h8001, "asr0");
        run_cmd(1, 0, 1, 1, 2'd1, 4'd1, 3'd1, 16'h0000, 16'h8000, 16'h0001, "sub_ovf");

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 7) == 0) idle_cycle("rand_idle");
            run_cmd(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom),
                    3'($urandom_range(0, 7)), W'($urandom), W'($urandom), W'($urandom), "rand");
        end

        // Reset in the middle of a command must abort it without writeback.
        asel = 1; bsel = 0; loadc = 1; loads = 1; shift = 0; shamt = 0;
        alu_op = 3'd4; A = 16'h00FF; B = 16'h00FF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_c = '0; m_st = '0;
        check("midrst_C", 64'(C), 64'(0));
        check("midrst_status", 64'(status), 64'(0));
        check("midrst_ready", 64'(in_ready), 64'(1));
        check("midrst_ovalid", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("midrst_no_pulse", 64'(pulses), 64'(0));
        run_cmd(1, 0, 1, 1, 2'd0, 4'd0, 3'd0, 16'h0000, 16'h0003, 16'h0004, "post_rst_add");
        check("post_rst_C_const", 64'(C), 64'h0007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
